rocketcpu_wb_streamer: RTL and testbench

Wishbone read initiator that fetches a block of 32-bit words from the SPRAM-backed Wishbone RAM and presents them as a valid/ready sample stream to the audio datapath. Software programs a base byte address and a word count, then pulses start; the block walks the region, optionally looping, and buffers words in a small FIFO. It sits between the RocketCPU RAM slave port (as a second initiator through the bus arbiter) and the audio output pipeline.

---
 rtl/rocketcpu_wb_streamer_pkg.sv | 12 +
 rtl/rocketcpu_sample_fifo.sv | 58 +++++
 rtl/rocketcpu_wb_streamer.sv | 171 +++++++++++++++++
 tb/tb_rocketcpu_wb_streamer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rocketcpu_wb_streamer_pkg.sv
// Shared encodings for the Wishbone sample streamer: engine states and timeout limit.
package rocketcpu_wb_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/rocketcpu_sample_fifo.sv
// Sample FIFO (DEPTH x 32) with flush; head word reads as zero while empty.
module rocketcpu_sample_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [31:0]                push_data,
  input  logic                       pop,
  output logic [31:0]                pop_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? 32'h0 : mem[rd_ptr];

endmodule

// File: rtl/rocketcpu_wb_streamer.sv
// Wishbone read initiator streaming a block of RAM words into a sample FIFO.
// Optional REQ timeout with sticky o_err: define ROCKETCPU_STREAMER_TIMEOUT_EN.
module rocketcpu_wb_streamer
  import rocketcpu_wb_streamer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ACK_GAP    = 2
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [31:0] i_base,
  input  logic [15:0] i_len,
  input  logic        i_loop,
  output logic        o_busy,
  output logic        o_err,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic        o_wb_cyc,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack,
  output logic [31:0] o_smp_data,
  output logic        o_smp_valid,
  input  logic        i_smp_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (ACK_GAP > 1) ? $clog2(ACK_GAP) : 1;

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   idx_q, idx_d;
  logic          loop_q, loop_d;
  logic          stop_q, stop_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          gap_done;
  logic          fifo_flush;
  logic          fifo_push;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;

`ifdef ROCKETCPU_STREAMER_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`endif

  assign gap_done  = (gap_q == GW'(ACK_GAP - 1));
  assign fifo_full = (fifo_count == CW'(FIFO_DEPTH));

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      loop_q  <= 1'b0;
      stop_q  <= 1'b0;
      gap_q   <= '0;
`ifdef ROCKETCPU_STREAMER_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      loop_q  <= loop_d;
      stop_q  <= stop_d;
      gap_q   <= gap_d;
`ifdef ROCKETCPU_STREAMER_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    loop_d     = loop_q;
    stop_d     = stop_q;
    gap_d      = gap_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
`ifdef ROCKETCPU_STREAMER_TIMEOUT_EN
    tmo_d      = '0;
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
        if (i_start && (i_len != 16'd0)) begin
          fifo_flush = 1'b1;
          base_d     = i_base & 32'hFFFF_FFFC;
          len_d      = i_len;
          loop_d     = i_loop;
          idx_d      = '0;
          state_d    = ST_REQ;
`ifdef ROCKETCPU_STREAMER_TIMEOUT_EN
          err_d      = 1'b0;
`endif
        end
      end
      ST_REQ: begin
        if (i_stop) stop_d = 1'b1;
        if (i_wb_ack) begin
          fifo_push = 1'b1;
          idx_d     = idx_q + 16'd1;
          gap_d     = '0;
          state_d   = ST_GAP;
        end
`ifdef ROCKETCPU_STREAMER_TIMEOUT_EN
        else if (tmo_q == TIMEOUT_LIMIT - 8'd1) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      ST_GAP: begin
        if (i_stop) stop_d = 1'b1;
        if (!gap_done) begin
          gap_d = gap_q + 1'b1;
        end else if (stop_q || i_stop) begin
          state_d = ST_IDLE;
        end else if ((idx_q == len_q) && !loop_q) begin
          state_d = ST_IDLE;
        end else begin
          // Wrap may happen while parked here waiting for FIFO space.
          if (idx_q == len_q) idx_d = '0;
          if (!fifo_full) state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  rocketcpu_sample_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_wb_clk),
    .rst       (i_wb_rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (i_wb_rdt),
    .pop       (i_smp_ready),
    .pop_data  (o_smp_data),
    .count     (fifo_count)
  );

  assign o_busy      = (state_q != ST_IDLE);
  assign o_wb_cyc    = (state_q == ST_REQ);
  assign o_wb_adr    = base_q + {14'b0, idx_q, 2'b00};
  assign o_wb_sel    = 4'hF;
  assign o_wb_we     = 1'b0;
  assign o_smp_valid = (fifo_count != '0);

`ifdef ROCKETCPU_STREAMER_TIMEOUT_EN
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_rocketcpu_wb_streamer.sv
// Directed bench for rocketcpu_wb_streamer with a RAM-slave model and sample scoreboard.
module tb_rocketcpu_wb_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] base = '0;
  logic [15:0] len = '0;
  logic        loop = 1'b0;
  logic        busy, err;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic [31:0] smp_data;
  logic        smp_valid;
  logic        smp_ready = 1'b0;

  logic        hold_ack = 1'b0;
  logic        never_ack = 1'b0;
  int          slv_cnt;

  logic [31:0] exp_q[$];
  logic [31:0] m_base;
  logic [15:0] m_len, m_idx;
  logic        m_loop;
  int          ack_count = 0;
  int          pop_count = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  rocketcpu_wb_streamer dut (
    .i_wb_clk    (clk),
    .i_wb_rst    (rst),
    .i_start     (start),
    .i_stop      (stop),
    .i_base      (base),
    .i_len       (len),
    .i_loop      (loop),
    .o_busy      (busy),
    .o_err       (err),
    .o_wb_adr    (wb_adr),
    .o_wb_sel    (wb_sel),
    .o_wb_we     (wb_we),
    .o_wb_cyc    (wb_cyc),
    .i_wb_rdt    (wb_rdt),
    .i_wb_ack    (wb_ack),
    .o_smp_data  (smp_data),
    .o_smp_valid (smp_valid),
    .i_smp_ready (smp_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // RAM slave: ack two cycles after cyc; hold_ack keeps ack up one extra cycle.
  assign wb_rdt = ram_word(wb_adr);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack  <= 1'b0;
      slv_cnt <= 0;
    end else if (!wb_cyc) begin
      wb_ack  <= 1'b0;
      slv_cnt <= 0;
    end else begin
      slv_cnt <= slv_cnt + 1;
      wb_ack  <= !never_ack && ((slv_cnt == 1) || (hold_ack && slv_cnt >= 1));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accepted transfer: check address against the model walk, queue expected sample.
  always @(negedge clk) begin
    if (!rst && wb_cyc && wb_ack) begin
      check("wb_adr", wb_adr, m_base + {14'b0, m_idx, 2'b00});
      check("wb_sel_we", {27'b0, wb_sel, wb_we}, {27'b0, 4'hF, 1'b0});
      exp_q.push_back(ram_word(m_base + {14'b0, m_idx, 2'b00}));
      ack_count++;
      if (m_loop && (m_idx + 16'd1 == m_len)) m_idx = '0;
      else m_idx = m_idx + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (!rst && smp_valid && smp_ready) begin
      pop_count++;
      if (exp_q.size() == 0) check("smp_extra", 32'd1, 32'd0);
      else check("smp_data", smp_data, exp_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge that samples i_start.
  task automatic start_run(input logic [31:0] b, input logic [15:0] l, input logic lp);
    base = b; len = l; loop = lp; start = 1'b1;
    if (l != 0) begin
      m_base = b & 32'hFFFF_FFFC; m_len = l; m_idx = '0; m_loop = lp;
    end
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    for (k = 0; k < max_cyc && busy; k++) step(1);
    if (busy) check("idle_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    for (k = 0; k < max_cyc && exp_q.size() != 0; k++) step(1);
    check("drain_left", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    exp_q.delete();
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    int a0, p0, cyc_hi;
    m_base = '0; m_len = '0; m_idx = '0; m_loop = 1'b0;

    // Reset values
    step(2);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_cyc", wb_cyc, 0);
    check("rst_adr", wb_adr, 0);
    check("rst_valid", smp_valid, 0);
    check("rst_data", smp_data, 0);
    check("rst_sel_we", {wb_sel, wb_we}, {4'hF, 1'b0});
    rst = 1'b0;
    step(2);

    // One pass of 3 words with ready high: cycle-exact cyc pattern
    smp_ready = 1'b1;
    start_run(32'h100, 16'd3, 1'b0);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("a_cyc_k%0d", k), wb_cyc, ((k % 5) < 3) && (k < 15));
      if (k == 0)  check("a_busy_k0", busy, 1);
      if (k == 2)  check("a_valid_k2", smp_valid, 0);
      if (k == 3)  check("a_valid_k3", smp_valid, 1);
      if (k == 14) check("a_busy_k14", busy, 1);
      if (k == 15) check("a_busy_k15", busy, 0);
      step(1);
    end
    wait_drain(20);
    check("a_acks", ack_count, 3);

    // Looping len 2 with ready low: fills FIFO then parks
    smp_ready = 1'b0;
    a0 = ack_count;
    start_run(32'h103, 16'd2, 1'b1);
    step(40);
    check("b_fill_acks", ack_count - a0, 4);
    check("b_valid_full", smp_valid, 1);
    cyc_hi = 0;
    for (int k = 0; k < 10; k++) begin
      if (wb_cyc) cyc_hi++;
      step(1);
    end
    check("b_parked_cyc", cyc_hi, 0);
    smp_ready = 1'b1;
    step(30);
    check("b_resumed", (ack_count - a0) > 6, 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    wait_idle(20);
    wait_drain(20);
    check("b_valid_end", smp_valid, 0);

    // Trailing acks held into the gap must not push twice
    hold_ack = 1'b1;
    smp_ready = 1'b0;
    a0 = ack_count; p0 = pop_count;
    start_run(32'h200, 16'd3, 1'b0);
    wait_idle(40);
    hold_ack = 1'b0;
    check("c_acks", ack_count - a0, 3);
    smp_ready = 1'b1;
    step(8);
    check("c_pops", pop_count - p0, 3);
    check("c_valid_end", smp_valid, 0);

    // Stop during the first REQ: one word, idle right after its gap
    a0 = ack_count; p0 = pop_count;
    start_run(32'h300, 16'd10, 1'b0);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(3);
    check("d_busy_k4", busy, 1);
    step(1);
    check("d_busy_k5", busy, 0);
    step(4);
    check("d_acks", ack_count - a0, 1);
    check("d_pops", pop_count - p0, 1);

    // Zero-length start is ignored
    start_run(32'h400, 16'd0, 1'b0);
    check("e_busy_len0", busy, 0);
    check("e_cyc_len0", wb_cyc, 0);
    step(3);
    check("e_busy_len0_late", busy, 0);

    // Slave that never acks
    never_ack = 1'b1;
    start_run(32'h500, 16'd1, 1'b0);
`ifdef ROCKETCPU_STREAMER_TIMEOUT_EN
    step(250);
    check("f_cyc_before_tmo", wb_cyc, 1);
    wait_idle(20);
    check("f_err_set", err, 1);
    check("f_cyc_dropped", wb_cyc, 0);
    check("f_no_push", smp_valid, 0);
    never_ack = 1'b0;
    start_run(32'h500, 16'd1, 1'b0);
    check("f_err_cleared", err, 0);
    wait_idle(20);
    wait_drain(10);
`else
    step(300);
    check("f_cyc_waits", wb_cyc, 1);
    check("f_busy_waits", busy, 1);
    check("f_err_tied", err, 0);
    never_ack = 1'b0;
    do_reset();
`endif

    // Asynchronous reset in the second REQ with a word already buffered
    smp_ready = 1'b0;
    start_run(32'h600, 16'd3, 1'b0);
    step(5);
    check("g_cyc_pre", wb_cyc, 1);
    check("g_valid_pre", smp_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("g_cyc_rst", wb_cyc, 0);
    check("g_busy_rst", busy, 0);
    check("g_valid_rst", smp_valid, 0);
    check("g_data_rst", smp_data, 0);
    check("g_adr_rst", wb_adr, 0);
    check("g_err_rst", err, 0);
    exp_q.delete();
    step(2);
    rst = 1'b0;
    step(3);
    check("g_idle_after", {busy, wb_cyc, smp_valid}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
